// File: rtl/commit_pkg.sv
// Shared constants and FSM state type for the commit monitor.
package commit_pkg;

    localparam logic [31:0] EBREAK_INST       = 32'h0010_0073;
    localparam logic [63:0] HALT_TIMEOUT_CODE = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} mon_state_t;

endpackage

// File: rtl/commit_trace_ring.sv
// Ring buffer of the most recently retired PCs.
// The ring is read combinationally by age: index 0 is the newest entry.
module commit_trace_ring
    import commit_pkg::*;
#(
    parameter int unsigned TRACE_DEPTH = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [63:0]                    wr_pc,
    input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
    output logic [63:0]                    rd_pc,
    output logic [63:0]                    last_pc
);
    localparam int unsigned IDX_W = $clog2(TRACE_DEPTH);

    logic [63:0]      mem_q [TRACE_DEPTH];
    logic [63:0]      mem_d [TRACE_DEPTH];
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] rd_slot, last_slot;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_pc;
            wr_ptr_d        = wr_ptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            for (int unsigned i = 0; i < TRACE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // Power-of-two depth lets the index arithmetic wrap naturally.
    assign rd_slot   = wr_ptr_q - IDX_W'(1) - rd_idx;
    assign last_slot = wr_ptr_q - IDX_W'(1);
    assign rd_pc     = mem_q[rd_slot];
    assign last_pc   = mem_q[last_slot];

endmodule

// File: rtl/commit_monitor.sv
// Retire-stage monitor: ebreak halt detection, counters and PC trace.
// Optional idle watchdog enabled by defining COMMIT_WATCHDOG_EN.
module commit_monitor
    import commit_pkg::*;
#(
    parameter int unsigned TRACE_DEPTH = 16,
    parameter int unsigned WDT_CYCLES  = 100000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           commit_valid,
    input  logic [63:0]                    commit_pc,
    input  logic [31:0]                    commit_inst,
    input  logic [63:0]                    commit_a0,
    output logic                           stall_req,
    output logic                           halt_valid,
    output logic [63:0]                    halt_code,
    output logic [63:0]                    halt_pc,
    output logic [63:0]                    inst_count,
    output logic [63:0]                    cycle_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
    output logic [63:0]                    trace_rd_pc,
    output logic                           timeout
);
    if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0 || WDT_CYCLES == 0) begin : g_bad_cfg
        $error("commit_monitor: TRACE_DEPTH must be a power of 2 >= 2 and WDT_CYCLES > 0");
    end

    mon_state_t  state_q, state_d;
    logic [63:0] inst_count_q, inst_count_d;
    logic [63:0] cycle_count_q, cycle_count_d;
    logic [63:0] halt_code_q, halt_code_d;
    logic [63:0] halt_pc_q, halt_pc_d;
    logic [63:0] last_pc;
    logic        in_run, commit_run, ebreak_hit, wdt_fire;

    assign in_run     = (state_q == RUN);
    assign commit_run = in_run && commit_valid;
    assign ebreak_hit = commit_run && (commit_inst == EBREAK_INST);

`ifdef COMMIT_WATCHDOG_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] idle_q, idle_d;
    logic             timeout_q, timeout_d;

    // A commit in the expiry cycle clears the count, so ebreak wins there.
    always_comb begin
        idle_d   = idle_q;
        wdt_fire = 1'b0;
        if (in_run) begin
            if (commit_valid) begin
                idle_d = '0;
            end else begin
                idle_d   = idle_q + WDT_W'(1);
                wdt_fire = (idle_d == WDT_W'(WDT_CYCLES));
            end
        end
        timeout_d = timeout_q | wdt_fire;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign wdt_fire = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:       if (ebreak_hit || wdt_fire) state_d = HALT_PEND;
            HALT_PEND: state_d = HALTED;
            HALTED:    state_d = HALTED;
            default:   state_d = RUN;
        endcase
    end

    always_comb begin
        stall_req  = (state_q != RUN);
        halt_valid = (state_q == HALT_PEND);
    end

    always_comb begin
        inst_count_d  = inst_count_q + (commit_run ? 64'd1 : 64'd0);
        cycle_count_d = cycle_count_q + (in_run ? 64'd1 : 64'd0);
        halt_code_d   = halt_code_q;
        halt_pc_d     = halt_pc_q;
        if (ebreak_hit) begin
            halt_code_d = commit_a0;
            halt_pc_d   = commit_pc;
        end else if (wdt_fire) begin
            halt_code_d = HALT_TIMEOUT_CODE;
            halt_pc_d   = last_pc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inst_count_q  <= '0;
            cycle_count_q <= '0;
            halt_code_q   <= '0;
            halt_pc_q     <= '0;
        end else begin
            inst_count_q  <= inst_count_d;
            cycle_count_q <= cycle_count_d;
            halt_code_q   <= halt_code_d;
            halt_pc_q     <= halt_pc_d;
        end
    end

    commit_trace_ring #(
        .TRACE_DEPTH(TRACE_DEPTH)
    ) u_ring (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (commit_run),
        .wr_pc  (commit_pc),
        .rd_idx (trace_rd_idx),
        .rd_pc  (trace_rd_pc),
        .last_pc(last_pc)
    );

    assign inst_count  = inst_count_q;
    assign cycle_count = cycle_count_q;
    assign halt_code   = halt_code_q;
    assign halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_commit_monitor.sv
// Self-checking bench for commit_monitor against a queue-based reference model.
module tb_commit_monitor;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ADDI   = 32'h0015_0513;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam int          WDT    = 8;
    localparam int          DEPTH  = 16;

    logic        clock, reset, commit_valid;
    logic [63:0] commit_pc, commit_a0;
    logic [31:0] commit_inst;
    logic        stall_req, halt_valid, timeout;
    logic [63:0] halt_code, halt_pc, inst_count, cycle_count, trace_rd_pc;
    logic [3:0]  trace_rd_idx;

    int tests = 0;
    int fails = 0;

    // Reference model: every retired PC kept in order, halt state as 0=run 1=pending 2=halted.
    logic [63:0] m_pcs[$];
    logic [63:0] m_inst, m_cycles, m_code, m_hpc;
    int          m_state, m_idle;
    bit          m_timeout;

    commit_monitor #(
        .TRACE_DEPTH(DEPTH),
        .WDT_CYCLES (WDT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .commit_valid(commit_valid),
        .commit_pc   (commit_pc),
        .commit_inst (commit_inst),
        .commit_a0   (commit_a0),
        .stall_req   (stall_req),
        .halt_valid  (halt_valid),
        .halt_code   (halt_code),
        .halt_pc     (halt_pc),
        .inst_count  (inst_count),
        .cycle_count (cycle_count),
        .trace_rd_idx(trace_rd_idx),
        .trace_rd_pc (trace_rd_pc),
        .timeout     (timeout)
    );

    initial begin
        clock = 1'b0;
        forever #50 clock = ~clock;
    end

    function automatic void model_reset();
        m_pcs.delete();
        m_inst = '0; m_cycles = '0; m_code = '0; m_hpc = '0;
        m_state = 0; m_idle = 0; m_timeout = 1'b0;
    endfunction

    function automatic logic [63:0] model_trace(int idx);
        if (idx < m_pcs.size()) return m_pcs[m_pcs.size() - 1 - idx];
        return '0;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        commit_valid = 1'b0; commit_pc = '0; commit_inst = '0; commit_a0 = '0;
        trace_rd_idx = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic step_commit(input bit v, input logic [63:0] pc, input logic [31:0] inst,
                               input logic [63:0] a0);
        commit_valid = v; commit_pc = pc; commit_inst = inst; commit_a0 = a0;
        @(posedge clock);
        if (m_state == 0) begin
            m_cycles++;
            if (v) begin
                m_inst++;
                m_pcs.push_back(pc);
                m_idle = 0;
                if (inst == EBREAK) begin
                    m_code = a0; m_hpc = pc; m_state = 1;
                end
            end else begin
                m_idle++;
`ifdef COMMIT_WATCHDOG_EN
                if (m_idle == WDT) begin
                    m_code = '1; m_hpc = model_trace(0); m_timeout = 1'b1; m_state = 1;
                end
`endif
            end
        end else if (m_state == 1) begin
            m_state = 2;
        end
        #1;
        commit_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if ({stall_req, halt_valid, timeout, halt_code, halt_pc, inst_count, cycle_count} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got st=%b hv=%b to=%b code=%h pc=%h ic=%h cc=%h, want all 0",
                     stall_req, halt_valid, timeout, halt_code, halt_pc, inst_count, cycle_count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            trace_rd_idx = 4'(i);
            #1;
            tests++;
            if (trace_rd_pc !== 64'd0) begin
                fails++;
                $display("FAIL reset_trace[%0d] got %h want 0", i, trace_rd_pc);
            end
        end
    endtask

    task automatic test_basic_halt();
        apply_reset();
        for (int i = 0; i < 5; i++) step_commit(1, 64'h8000_0000 + 64'(4 * i), ADDI, {$urandom, $urandom});
        tests++;
        if (halt_valid !== 1'b0 || stall_req !== 1'b0) begin
            fails++;
            $display("FAIL pre_halt got hv=%b st=%b want 0 0", halt_valid, stall_req);
        end
        step_commit(1, 64'h8000_0014, EBREAK, 64'd0);
        tests++;
        if (halt_valid !== 1'b1 || stall_req !== 1'b1) begin
            fails++;
            $display("FAIL halt_pulse got hv=%b st=%b want 1 1", halt_valid, stall_req);
        end
        tests++;
        if (halt_code !== 64'd0 || halt_pc !== 64'h8000_0014 || inst_count !== 64'd6) begin
            fails++;
            $display("FAIL halt_regs got code=%h pc=%h ic=%0d want 0 80000014 6", halt_code, halt_pc, inst_count);
        end
        tests++;
        if (cycle_count !== m_cycles) begin
            fails++;
            $display("FAIL halt_cycles got %0d want %0d", cycle_count, m_cycles);
        end
        for (int i = 0; i < 3; i++) begin
            step_commit(0, '0, '0, '0);
            tests++;
            if (halt_valid !== 1'b0 || stall_req !== 1'b1) begin
                fails++;
                $display("FAIL post_halt[%0d] got hv=%b st=%b want 0 1", i, halt_valid, stall_req);
            end
        end
    endtask

    task automatic test_halt_code();
        logic [63:0] ebreak_pc;
        apply_reset();
        step_commit(1, 64'h1000, ADDI, '0);
        step_commit(1, 64'h1004, ECALL, '0);
        ebreak_pc = {$urandom, $urandom} & ~64'h3;
        step_commit(1, ebreak_pc, EBREAK, 64'h1);
        tests++;
        if (halt_code !== 64'h1 || halt_valid !== 1'b1) begin
            fails++;
            $display("FAIL code_one got code=%h hv=%b want 1 1", halt_code, halt_valid);
        end
        for (int i = 0; i < 5; i++) step_commit(1, {$urandom, $urandom}, EBREAK, {$urandom, $urandom});
        trace_rd_idx = 4'd0;
        #1;
        tests++;
        if (inst_count !== 64'd3 || trace_rd_pc !== ebreak_pc) begin
            fails++;
            $display("FAIL frozen got ic=%0d trace0=%h want 3 %h", inst_count, trace_rd_pc, ebreak_pc);
        end
        tests++;
        if (halt_code !== 64'h1 || halt_pc !== ebreak_pc || cycle_count !== m_cycles) begin
            fails++;
            $display("FAIL held got code=%h pc=%h cc=%0d want 1 %h %0d", halt_code, halt_pc, cycle_count, ebreak_pc, m_cycles);
        end
    endtask

    task automatic test_ring();
        logic [63:0] pcs [20];
        apply_reset();
        for (int i = 0; i < 20; i++) pcs[i] = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) step_commit(1, pcs[i], ADDI, '0);
        trace_rd_idx = 4'd5;
        #1;
        tests++;
        if (trace_rd_pc !== 64'd0) begin
            fails++;
            $display("FAIL ring_unwritten got %h want 0", trace_rd_pc);
        end
        trace_rd_idx = 4'd2;
        #1;
        tests++;
        if (trace_rd_pc !== pcs[0]) begin
            fails++;
            $display("FAIL ring_idx2 got %h want %h", trace_rd_pc, pcs[0]);
        end
        for (int i = 3; i < 20; i++) step_commit(1, pcs[i], MRET, '0);
        trace_rd_idx = 4'd0;
        #1;
        tests++;
        if (trace_rd_pc !== pcs[19]) begin
            fails++;
            $display("FAIL ring_newest got %h want %h", trace_rd_pc, pcs[19]);
        end
        trace_rd_idx = 4'd15;
        #1;
        tests++;
        if (trace_rd_pc !== pcs[4]) begin
            fails++;
            $display("FAIL ring_oldest got %h want %h", trace_rd_pc, pcs[4]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            trace_rd_idx = 4'(i);
            #1;
            tests++;
            if (trace_rd_pc !== model_trace(i)) begin
                fails++;
                $display("FAIL ring_model[%0d] got %h want %h", i, trace_rd_pc, model_trace(i));
            end
        end
    endtask

    task automatic test_reset_in_pend();
        apply_reset();
        step_commit(1, 64'h2000, ADDI, '0);
        commit_valid = 1'b1; commit_pc = 64'h2004; commit_inst = EBREAK; commit_a0 = 64'h77;
        @(posedge clock);
        reset = 1'b1;
        commit_valid = 1'b0;
        #1;
        tests++;
        if ({stall_req, halt_valid, timeout, halt_code, halt_pc, inst_count, cycle_count} !== '0) begin
            fails++;
            $display("FAIL pend_reset got st=%b hv=%b code=%h pc=%h ic=%h cc=%h want all 0",
                     stall_req, halt_valid, halt_code, halt_pc, inst_count, cycle_count);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            tests++;
            if (halt_valid !== 1'b0) begin
                fails++;
                $display("FAIL pend_no_pulse got hv=%b want 0", halt_valid);
            end
        end
        reset = 1'b0;
        model_reset();
        step_commit(1, 64'h3000, ADDI, '0);
        tests++;
        if (stall_req !== 1'b0 || inst_count !== 64'd1 || cycle_count !== 64'd1) begin
            fails++;
            $display("FAIL pend_rerun got st=%b ic=%0d cc=%0d want 0 1 1", stall_req, inst_count, cycle_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] inst;
        bit          v;
        int          ridx;
        logic [63:0] a0;
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            v = ($urandom_range(0, 3) != 0) || (m_idle >= WDT - 2);
            case ($urandom_range(0, 3))
                0:       inst = ADDI;
                1:       inst = ECALL;
                2:       inst = MRET;
                default: begin
                    inst = $urandom;
                    if (inst == EBREAK) inst = ADDI;
                end
            endcase
            step_commit(v, {$urandom, $urandom}, inst, {$urandom, $urandom});
            ridx = $urandom_range(0, DEPTH - 1);
            trace_rd_idx = 4'(ridx);
            #1;
            tests++;
            if (inst_count !== m_inst || cycle_count !== m_cycles) begin
                fails++;
                $display("FAIL rnd_count[%0d] got ic=%0d cc=%0d want %0d %0d", n, inst_count, cycle_count, m_inst, m_cycles);
            end
            tests++;
            if (trace_rd_pc !== model_trace(ridx) || stall_req !== 1'b0 || halt_valid !== 1'b0) begin
                fails++;
                $display("FAIL rnd_trace[%0d] idx=%0d got %h st=%b hv=%b want %h 0 0",
                         n, ridx, trace_rd_pc, stall_req, halt_valid, model_trace(ridx));
            end
        end
        a0 = {$urandom, $urandom};
        step_commit(1, 64'hC0DE_0000, EBREAK, a0);
        tests++;
        if (halt_valid !== 1'b1 || halt_code !== m_code || halt_pc !== m_hpc || inst_count !== m_inst) begin
            fails++;
            $display("FAIL rnd_halt got hv=%b code=%h pc=%h ic=%0d want 1 %h %h %0d",
                     halt_valid, halt_code, halt_pc, inst_count, m_code, m_hpc, m_inst);
        end
    endtask

    task automatic test_watchdog();
`ifdef COMMIT_WATCHDOG_EN
        apply_reset();
        step_commit(1, 64'h4000, ADDI, '0);
        for (int i = 0; i < WDT - 1; i++) begin
            step_commit(0, '0, '0, '0);
            tests++;
            if (halt_valid !== 1'b0 || timeout !== 1'b0) begin
                fails++;
                $display("FAIL wdt_early[%0d] got hv=%b to=%b want 0 0", i, halt_valid, timeout);
            end
        end
        step_commit(0, '0, '0, '0);
        tests++;
        if (halt_valid !== 1'b1 || timeout !== 1'b1 || halt_code !== 64'hFFFF_FFFF_FFFF_FFFF || halt_pc !== 64'h4000) begin
            fails++;
            $display("FAIL wdt_fire got hv=%b to=%b code=%h pc=%h want 1 1 ffffffffffffffff 4000",
                     halt_valid, timeout, halt_code, halt_pc);
        end
        step_commit(0, '0, '0, '0);
        tests++;
        if (halt_valid !== 1'b0 || timeout !== 1'b1 || stall_req !== 1'b1 || cycle_count !== m_cycles) begin
            fails++;
            $display("FAIL wdt_after got hv=%b to=%b st=%b cc=%0d want 0 1 1 %0d", halt_valid, timeout, stall_req, cycle_count, m_cycles);
        end
        apply_reset();
        step_commit(1, 64'h5000, ADDI, '0);
        for (int i = 0; i < WDT - 1; i++) step_commit(0, '0, '0, '0);
        step_commit(1, 64'h5004, EBREAK, 64'h55);
        tests++;
        if (halt_valid !== 1'b1 || timeout !== 1'b0 || halt_code !== 64'h55 || halt_pc !== 64'h5004) begin
            fails++;
            $display("FAIL wdt_ebreak_wins got hv=%b to=%b code=%h pc=%h want 1 0 55 5004",
                     halt_valid, timeout, halt_code, halt_pc);
        end
`else
        apply_reset();
        for (int i = 0; i < 3 * WDT; i++) step_commit(0, '0, '0, '0);
        tests++;
        if (timeout !== 1'b0 || stall_req !== 1'b0 || halt_valid !== 1'b0 || cycle_count !== m_cycles) begin
            fails++;
            $display("FAIL no_wdt got to=%b st=%b hv=%b cc=%0d want 0 0 0 %0d", timeout, stall_req, halt_valid, cycle_count, m_cycles);
        end
`endif
    endtask

    task automatic test_wrap();
        apply_reset();
        step_commit(1, 64'h6000, ADDI, '0);
        force dut.inst_count_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.inst_count_q;
        m_inst = '1;
        #1;
        tests++;
        if (inst_count !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            fails++;
            $display("FAIL wrap_preload got %h want ffffffffffffffff", inst_count);
        end
        step_commit(1, 64'h6004, ADDI, '0);
        trace_rd_idx = 4'd0;
        #1;
        tests++;
        if (inst_count !== 64'd0 || inst_count !== m_inst) begin
            fails++;
            $display("FAIL wrap_count got %h want 0", inst_count);
        end
        tests++;
        if (cycle_count !== m_cycles || trace_rd_pc !== 64'h6004 || stall_req !== 1'b0 || halt_valid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_side got cc=%0d tr=%h st=%b hv=%b want %0d 6004 0 0",
                     cycle_count, trace_rd_pc, stall_req, halt_valid, m_cycles);
        end
    endtask

    initial begin
        reset = 1'b1;
        commit_valid = 1'b0; commit_pc = '0; commit_inst = '0; commit_a0 = '0;
        trace_rd_idx = '0;
        model_reset();
        test_reset();
        test_basic_halt();
        test_halt_code();
        test_ring();
        test_reset_in_pend();
        test_random();
        test_watchdog();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL time_limit reached at %0t, tests=%0d", $time, tests);
        $fatal(1, "time limit");
    end

endmodule
